ll_data_table_insert: RTL and testbench
=======================================

// Module: ll_data_table_insert
// PURPOSE
//  Insert engine for the linked-list data table: inverse of the delete engine.
//  - Walks the bucket chain from the head ptr supplied with the task.
//  - On key match, overwrites the value in place.
//  - On miss, pops a free address from the empty ptr storage and writes the new entry there.
//  - Links the new entry either into the head table (empty chain) or onto the tail's next_ptr.
//  - Reports the outcome on a valid/ready result port.
// PARAMETERS
//  RAM_LATENCY  2                    rd_en -> rd_data_i valid delay, cycles (via ll_rd_data_val_helper)
//  A_WIDTH      LL_TABLE_ADDR_WIDTH  data RAM / pointer width
// PORTS
//  clk_i               in   1        single clock
//  rst_i               in   1        asynchronous, active-high reset
//  task_i              in   ll_ht_pdata_t  cmd.key, cmd.value, head_ptr, head_ptr_val
//  task_valid_i        in   1        task handshake valid
//  task_ready_o        out  1        high only in IDLE_S
//  rd_data_i           in   ll_ram_data_t  RAM read data: key, value, next_ptr, next_ptr_val
//  rd_addr_o           out  A_WIDTH  RAM read address
//  rd_en_o             out  1        RAM read strobe, 1-cycle pulse per hop
//  wr_addr_o           out  A_WIDTH  RAM write address
//  wr_data_o           out  ll_ram_data_t  RAM write data
//  wr_en_o             out  1        RAM write strobe
//  empty_ptr_i         in   A_WIDTH  head of free-address FIFO (show-ahead)
//  empty_ptr_val_i     in   1        free address available
//  empty_ptr_rd_ack_o  out  1        pop free address, 1-cycle pulse
//  ll_head_table_if    master        wr_data_ptr, wr_data_ptr_val, wr_en
//  result_o            out  ll_ht_result_t  cmd, rescode, chain_state
//  result_valid_o      out  1        result valid
//  result_ready_i      in   1        result accepted
// BEHAVIOUR
//  Reset: state=IDLE_S; task_ready_o=1; all strobes, result_valid_o and captured regs =0.
//  Reset mid-walk aborts without further writes. RAM is not repaired.
//  Task accept (valid&&ready) captures task_i.
//  - head_ptr_val=0 -> NO_HEAD_PTR_S.
//  - head_ptr_val=1 -> READ_HEAD_S with rd_addr=head_ptr.
//  READ_HEAD_S/GO_ON_CHAIN_S:
//  - rd_en_o pulses on the state's first tick and on the cycle after each non-terminal rd_data_val.
//  - Data is evaluated when rd_data_val is high, RAM_LATENCY cycles after rd_en.
//    - key==cmd.key -> KEY_MATCH_S; chain_state = IN_HEAD if READ_HEAD_S, else IN_TAIL if next_ptr_val=0, else IN_MIDDLE.
//    - no match, next_ptr_val=0 -> ON_TAIL_S.
//    - no match, next_ptr_val=1 -> GO_ON_CHAIN_S, rd_addr<=next_ptr.
//  KEY_MATCH_S, 1 cycle:
//  - wr_en=1, wr_addr=rd_addr, wr_data=read data with value replaced by cmd.value.
//  - -> REPORT_S, rescode LL_INSERT_SUCCESS_SAME_KEY.
//  NO_HEAD_PTR_S, 1 cycle; empty_ptr_val_i sampled this cycle only:
//  - empty_ptr_val_i=1:
//    - wr_en=1, wr_addr=empty_ptr_i, wr_data={cmd.key,cmd.value,next_ptr=0,val=0}.
//    - head wr_en=1, head wr_data_ptr=empty_ptr_i, wr_data_ptr_val=1.
//    - rd_ack=1.
//    - -> REPORT_S, LL_INSERT_SUCCESS, LL_NO_CHAIN.
//  - empty_ptr_val_i=0 -> FULL_S.
//  ON_TAIL_S, 2 cycles:
//  - Cycle 0, empty_ptr_val_i=1:
//    - write new entry at empty_ptr_i, next_ptr_val=0.
//    - rd_ack=1; latch new_ptr.
//  - Cycle 0, empty_ptr_val_i=0 -> FULL_S, nothing written.
//  - Cycle 1: wr_addr=rd_addr (tail), wr_data=tail data with next_ptr=new_ptr, next_ptr_val=1.
//    - -> REPORT_S, LL_INSERT_SUCCESS, LL_IN_TAIL_NO_MATCH.
//  FULL_S: rescode LL_INSERT_NOT_SUCCESS_TABLE_IS_FULL. chain_state = LL_NO_CHAIN or LL_IN_TAIL_NO_MATCH.
//  REPORT_S/FULL_S:
//  - result_valid_o=1; result_o stays stable while result_ready_i=0.
//  - Exit to IDLE_S on valid&&ready.
//  - task_valid_i is ignored (ready=0).
//  Mutual exclusion:
//  - At most one of wr_en_o / head wr_en per cycle.
//  - rd_ack at most once per task; never while empty_ptr_val_i=0.
// TESTING
//  - Empty bucket, free ptr 0x05, key 0xAB val 0x11:
//    -> RAM[5]={AB,11,0,0}; head ptr 5 val 1; one ack; SUCCESS, NO_CHAIN.
//  - Chain 3->7, key at 7, new val 0x22:
//    -> 2 reads, RAM[7].value=22, no ack; SAME_KEY, IN_TAIL.
//  - Chain 3->7, key at 3:
//    -> 1 read, write at 3 only; SAME_KEY, IN_HEAD.
//  - Chain 3->7, miss, free ptr 9:
//    -> RAM[9] written, then RAM[7].next_ptr=9 val 1; SUCCESS, IN_TAIL_NO_MATCH.
//  - Miss with empty_ptr_val_i=0:
//    -> no write, no ack; TABLE_IS_FULL.
//  - Hold result_ready_i=0 10 cycles with task_valid_i=1:
//    -> result stable, task_ready_o=0.
//  - Assert rst_i mid-walk:
//    -> IDLE, strobes 0, no writes.

Source files
------------

// File: rtl/ll_data_table_insert_if.sv
`default_nettype none
// ============================================================================
//  Module   : ll_data_table_insert_if
//  Purpose  : Head-table write port used by the linked-list insert engine.
//  Revision : 1.0 - initial release
// ============================================================================
interface ll_data_table_insert_if #(
    parameter int A_WIDTH = 8
) ();
    logic [A_WIDTH-1:0] wr_data_ptr;
    logic               wr_data_ptr_val;
    logic               wr_en;

    modport master (
        output wr_data_ptr,
        output wr_data_ptr_val,
        output wr_en
    );

    modport slave (
        input  wr_data_ptr,
        input  wr_data_ptr_val,
        input  wr_en
    );
endinterface
`default_nettype wire

// File: rtl/ll_data_table_insert.sv
`default_nettype none
// ============================================================================
//  Module   : ll_data_table_insert
//  Purpose  : Linked-list data table insert engine (walk, overwrite or append).
//             task_i/rd_data_i/wr_data_o = {key, value, ptr, ptr_val};
//             result_o = {key, value, rescode[1:0], chain_state[2:0]}.
//  Revision : 1.0 - initial release
// ============================================================================
module ll_data_table_insert #(
    parameter int RAM_LATENCY = 2,
    parameter int A_WIDTH     = 8,
    parameter int KEY_WIDTH   = 8,
    parameter int VALUE_WIDTH = 8
) (
    input  wire logic                                   clk_i,
    input  wire logic                                   rst_i,
    input  wire logic [KEY_WIDTH+VALUE_WIDTH+A_WIDTH:0] task_i,
    input  wire logic                                   task_valid_i,
    output logic                                        task_ready_o,
    input  wire logic [KEY_WIDTH+VALUE_WIDTH+A_WIDTH:0] rd_data_i,
    output logic [A_WIDTH-1:0]                          rd_addr_o,
    output logic                                        rd_en_o,
    output logic [A_WIDTH-1:0]                          wr_addr_o,
    output logic [KEY_WIDTH+VALUE_WIDTH+A_WIDTH:0]      wr_data_o,
    output logic                                        wr_en_o,
    input  wire logic [A_WIDTH-1:0]                     empty_ptr_i,
    input  wire logic                                   empty_ptr_val_i,
    output logic                                        empty_ptr_rd_ack_o,
    ll_data_table_insert_if.master                      ll_head_table_if,
    output logic [KEY_WIDTH+VALUE_WIDTH+4:0]            result_o,
    output logic                                        result_valid_o,
    input  wire logic                                   result_ready_i
);

    localparam int D_WIDTH = KEY_WIDTH + VALUE_WIDTH + A_WIDTH + 1;

    localparam logic [2:0] IDLE_S        = 3'd0;
    localparam logic [2:0] NO_HEAD_PTR_S = 3'd1;
    localparam logic [2:0] READ_HEAD_S   = 3'd2;
    localparam logic [2:0] GO_ON_CHAIN_S = 3'd3;
    localparam logic [2:0] KEY_MATCH_S   = 3'd4;
    localparam logic [2:0] ON_TAIL_S     = 3'd5;
    localparam logic [2:0] FULL_S        = 3'd6;
    localparam logic [2:0] REPORT_S      = 3'd7;

    localparam logic [1:0] LL_INSERT_SUCCESS                   = 2'd0;
    localparam logic [1:0] LL_INSERT_SUCCESS_SAME_KEY          = 2'd1;
    localparam logic [1:0] LL_INSERT_NOT_SUCCESS_TABLE_IS_FULL = 2'd2;

    localparam logic [2:0] LL_NO_CHAIN         = 3'd0;
    localparam logic [2:0] LL_IN_HEAD          = 3'd1;
    localparam logic [2:0] LL_IN_MIDDLE        = 3'd2;
    localparam logic [2:0] LL_IN_TAIL          = 3'd3;
    localparam logic [2:0] LL_IN_TAIL_NO_MATCH = 3'd4;

    logic [2:0]             r_state;
    logic [KEY_WIDTH-1:0]   r_key;
    logic [VALUE_WIDTH-1:0] r_value;
    logic [A_WIDTH-1:0]     r_rd_addr;
    logic [KEY_WIDTH-1:0]   r_rd_key;
    logic [VALUE_WIDTH-1:0] r_rd_value;
    logic [A_WIDTH-1:0]     r_rd_next;
    logic                   r_rd_next_val;
    logic                   r_rd_pend;
    logic                   r_tail_phase;
    logic [A_WIDTH-1:0]     r_new_ptr;
    logic [1:0]             r_rescode;
    logic [2:0]             r_chain;
    logic [RAM_LATENCY-1:0] r_val_pipe;

    logic [KEY_WIDTH-1:0]   w_task_key;
    logic [VALUE_WIDTH-1:0] w_task_value;
    logic [A_WIDTH-1:0]     w_task_head;
    logic                   w_task_head_val;
    logic [KEY_WIDTH-1:0]   w_rd_key;
    logic [VALUE_WIDTH-1:0] w_rd_value;
    logic [A_WIDTH-1:0]     w_rd_next;
    logic                   w_rd_next_val;
    logic                   w_reading;
    logic                   w_rd_data_val;
    logic                   w_wr_en;
    logic [A_WIDTH-1:0]     w_wr_addr;
    logic [D_WIDTH-1:0]     w_wr_data;
    logic                   w_head_wr_en;
    logic                   w_ack;

    assign {w_task_key, w_task_value, w_task_head, w_task_head_val} = task_i;
    assign {w_rd_key, w_rd_value, w_rd_next, w_rd_next_val}         = rd_data_i;

    assign w_reading     = (r_state == READ_HEAD_S) || (r_state == GO_ON_CHAIN_S);
    assign w_rd_data_val = r_val_pipe[RAM_LATENCY-1];

    // Read-data valid tracker: rd_en delayed by the RAM latency.
    if (RAM_LATENCY == 1) begin : g_lat_one
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) r_val_pipe <= '0;
            else       r_val_pipe <= rd_en_o;
        end
    end else begin : g_lat_multi
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) r_val_pipe <= '0;
            else       r_val_pipe <= {r_val_pipe[RAM_LATENCY-2:0], rd_en_o};
        end
    end

    always_comb begin
        w_wr_en      = 1'b0;
        w_wr_addr    = r_rd_addr;
        w_wr_data    = {r_rd_key, r_rd_value, r_rd_next, r_rd_next_val};
        w_head_wr_en = 1'b0;
        w_ack        = 1'b0;
        case (r_state)
            KEY_MATCH_S: begin
                w_wr_en   = 1'b1;
                w_wr_data = {r_rd_key, r_value, r_rd_next, r_rd_next_val};
            end
            NO_HEAD_PTR_S: begin
                if (empty_ptr_val_i) begin
                    w_wr_en      = 1'b1;
                    w_wr_addr    = empty_ptr_i;
                    w_wr_data    = {r_key, r_value, {A_WIDTH{1'b0}}, 1'b0};
                    w_head_wr_en = 1'b1;
                    w_ack        = 1'b1;
                end
            end
            ON_TAIL_S: begin
                if (!r_tail_phase) begin
                    if (empty_ptr_val_i) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = empty_ptr_i;
                        w_wr_data = {r_key, r_value, {A_WIDTH{1'b0}}, 1'b0};
                        w_ack     = 1'b1;
                    end
                end else begin
                    // Second tick: hook the freshly written entry onto the old tail.
                    w_wr_en   = 1'b1;
                    w_wr_data = {r_rd_key, r_rd_value, r_new_ptr, 1'b1};
                end
            end
            default: ;
        endcase
    end

    assign task_ready_o       = (r_state == IDLE_S);
    assign rd_en_o            = w_reading && r_rd_pend;
    assign rd_addr_o          = r_rd_addr;
    assign wr_en_o            = w_wr_en;
    assign wr_addr_o          = w_wr_addr;
    assign wr_data_o          = w_wr_data;
    assign empty_ptr_rd_ack_o = w_ack;
    assign result_valid_o     = (r_state == REPORT_S) || (r_state == FULL_S);
    assign result_o           = {r_key, r_value, r_rescode, r_chain};

    assign ll_head_table_if.wr_en           = w_head_wr_en;
    assign ll_head_table_if.wr_data_ptr     = empty_ptr_i;
    assign ll_head_table_if.wr_data_ptr_val = 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= IDLE_S;
            r_key         <= '0;
            r_value       <= '0;
            r_rd_addr     <= '0;
            r_rd_key      <= '0;
            r_rd_value    <= '0;
            r_rd_next     <= '0;
            r_rd_next_val <= 1'b0;
            r_rd_pend     <= 1'b0;
            r_tail_phase  <= 1'b0;
            r_new_ptr     <= '0;
            r_rescode     <= '0;
            r_chain       <= '0;
        end else begin
            case (r_state)
                IDLE_S: begin
                    if (task_valid_i) begin
                        r_key     <= w_task_key;
                        r_value   <= w_task_value;
                        r_rd_addr <= w_task_head;
                        if (w_task_head_val) begin
                            r_state   <= READ_HEAD_S;
                            r_rd_pend <= 1'b1;
                        end else begin
                            r_state   <= NO_HEAD_PTR_S;
                        end
                    end
                end
                READ_HEAD_S, GO_ON_CHAIN_S: begin
                    if (rd_en_o) r_rd_pend <= 1'b0;
                    if (w_rd_data_val) begin
                        r_rd_key      <= w_rd_key;
                        r_rd_value    <= w_rd_value;
                        r_rd_next     <= w_rd_next;
                        r_rd_next_val <= w_rd_next_val;
                        if (w_rd_key == r_key) begin
                            r_state <= KEY_MATCH_S;
                            if (r_state == READ_HEAD_S) r_chain <= LL_IN_HEAD;
                            else if (!w_rd_next_val)    r_chain <= LL_IN_TAIL;
                            else                        r_chain <= LL_IN_MIDDLE;
                        end else if (!w_rd_next_val) begin
                            r_state      <= ON_TAIL_S;
                            r_tail_phase <= 1'b0;
                        end else begin
                            r_state   <= GO_ON_CHAIN_S;
                            r_rd_addr <= w_rd_next;
                            r_rd_pend <= 1'b1;
                        end
                    end
                end
                KEY_MATCH_S: begin
                    r_rescode <= LL_INSERT_SUCCESS_SAME_KEY;
                    r_state   <= REPORT_S;
                end
                NO_HEAD_PTR_S: begin
                    r_chain <= LL_NO_CHAIN;
                    if (empty_ptr_val_i) begin
                        r_rescode <= LL_INSERT_SUCCESS;
                        r_state   <= REPORT_S;
                    end else begin
                        r_rescode <= LL_INSERT_NOT_SUCCESS_TABLE_IS_FULL;
                        r_state   <= FULL_S;
                    end
                end
                ON_TAIL_S: begin
                    r_chain <= LL_IN_TAIL_NO_MATCH;
                    if (!r_tail_phase) begin
                        if (empty_ptr_val_i) begin
                            r_new_ptr    <= empty_ptr_i;
                            r_tail_phase <= 1'b1;
                        end else begin
                            r_rescode <= LL_INSERT_NOT_SUCCESS_TABLE_IS_FULL;
                            r_state   <= FULL_S;
                        end
                    end else begin
                        r_rescode    <= LL_INSERT_SUCCESS;
                        r_tail_phase <= 1'b0;
                        r_state      <= REPORT_S;
                    end
                end
                FULL_S, REPORT_S: begin
                    if (result_ready_i) r_state <= IDLE_S;
                end
                default: r_state <= IDLE_S;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ll_data_table_insert.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ll_data_table_insert
//  Purpose  : Directed vector bench for the linked-list insert engine.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ll_data_table_insert;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [24:0] task_i = '0;
    logic        task_valid_i = 1'b0;
    logic        task_ready_o;
    logic [24:0] rd_data_i = '0;
    logic [7:0]  rd_addr_o;
    logic        rd_en_o;
    logic [7:0]  wr_addr_o;
    logic [24:0] wr_data_o;
    logic        wr_en_o;
    logic [7:0]  empty_ptr_i = '0;
    logic        empty_ptr_val_i = 1'b0;
    logic        empty_ptr_rd_ack_o;
    logic [20:0] result_o;
    logic        result_valid_o;
    logic        result_ready_i = 1'b1;

    ll_data_table_insert_if #(.A_WIDTH(8)) u_head_if ();

    ll_data_table_insert #(
        .RAM_LATENCY(2), .A_WIDTH(8), .KEY_WIDTH(8), .VALUE_WIDTH(8)
    ) u_dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .task_i             (task_i),
        .task_valid_i       (task_valid_i),
        .task_ready_o       (task_ready_o),
        .rd_data_i          (rd_data_i),
        .rd_addr_o          (rd_addr_o),
        .rd_en_o            (rd_en_o),
        .wr_addr_o          (wr_addr_o),
        .wr_data_o          (wr_data_o),
        .wr_en_o            (wr_en_o),
        .empty_ptr_i        (empty_ptr_i),
        .empty_ptr_val_i    (empty_ptr_val_i),
        .empty_ptr_rd_ack_o (empty_ptr_rd_ack_o),
        .ll_head_table_if   (u_head_if),
        .result_o           (result_o),
        .result_valid_o     (result_valid_o),
        .result_ready_i     (result_ready_i)
    );

    always #5 clk = ~clk;

    // RAM / head table / free-list model with event counters
    logic [24:0] ram [0:255];
    logic [24:0] rd_q1;
    logic [7:0]  head_ptr_m;
    logic        head_val_m;
    int          n_rd, n_wr, n_ack, n_hwr, n_bad_ack;
    logic        tb_clr = 1'b0;

    always @(posedge clk) begin
        rd_q1     <= ram[rd_addr_o];
        rd_data_i <= rd_q1;
        if (tb_clr) begin
            for (int a = 0; a < 256; a++) ram[a] <= '0;
            ram[3]     <= {8'h30, 8'h31, 8'h07, 1'b1};
            ram[7]     <= {8'h70, 8'h71, 8'h00, 1'b0};
            head_ptr_m <= '0;
            head_val_m <= 1'b0;
            n_rd <= 0; n_wr <= 0; n_ack <= 0; n_hwr <= 0; n_bad_ack <= 0;
        end else begin
            if (wr_en_o) begin
                ram[wr_addr_o] <= wr_data_o;
                n_wr <= n_wr + 1;
            end
            if (u_head_if.wr_en) begin
                head_ptr_m <= u_head_if.wr_data_ptr;
                head_val_m <= u_head_if.wr_data_ptr_val;
                n_hwr <= n_hwr + 1;
            end
            if (rd_en_o) n_rd <= n_rd + 1;
            if (empty_ptr_rd_ack_o) n_ack <= n_ack + 1;
            if (empty_ptr_rd_ack_o && !empty_ptr_val_i) n_bad_ack <= n_bad_ack + 1;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        hpv;
        logic [7:0]  hp, key, val;
        logic        ev;
        logic [7:0]  ep;
        logic [1:0]  rc;
        logic [2:0]  cs;
        int          reads, writes, acks, hwr;
        logic [7:0]  hptr;
        logic        hval;
        logic [7:0]  a0;
        logic [24:0] d0;
        logic [7:0]  a1;
        logic [24:0] d1;
    } vec_t;

    vec_t vecs [8];

    task automatic clear_model();
        @(negedge clk); tb_clr = 1'b1;
        @(negedge clk); tb_clr = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [20:0] res;
        bit          got;
        clear_model();
        task_i          = {v.key, v.val, v.hp, v.hpv};
        empty_ptr_i     = v.ep;
        empty_ptr_val_i = v.ev;
        result_ready_i  = 1'b1;
        task_valid_i    = 1'b1;
        @(negedge clk);
        task_valid_i    = 1'b0;
        got = 1'b0;
        res = '0;
        for (int c = 0; c < 60 && !got; c++) begin
            if (result_valid_o) begin
                got = 1'b1;
                res = result_o;
            end else begin
                @(negedge clk);
            end
        end
        chk({v.name, "_result_seen"}, {31'd0, got}, 32'd1);
        @(negedge clk);
        chk({v.name, "_key"},     {24'd0, res[20:13]}, {24'd0, v.key});
        chk({v.name, "_value"},   {24'd0, res[12:5]},  {24'd0, v.val});
        chk({v.name, "_rescode"}, {30'd0, res[4:3]},   {30'd0, v.rc});
        chk({v.name, "_chain"},   {29'd0, res[2:0]},   {29'd0, v.cs});
        chk({v.name, "_reads"},   n_rd,  v.reads);
        chk({v.name, "_writes"},  n_wr,  v.writes);
        chk({v.name, "_acks"},    n_ack, v.acks);
        chk({v.name, "_head_wr"}, n_hwr, v.hwr);
        chk({v.name, "_head_ptr"}, {23'd0, head_ptr_m, head_val_m}, {23'd0, v.hptr, v.hval});
        chk({v.name, "_ram_a0"},  {7'd0, ram[v.a0]}, {7'd0, v.d0});
        chk({v.name, "_ram_a1"},  {7'd0, ram[v.a1]}, {7'd0, v.d1});
        chk({v.name, "_idle"},    {31'd0, task_ready_o}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{"empty_bucket", 1'b0, 8'h00, 8'hAB, 8'h11, 1'b1, 8'h05, 2'd0, 3'd0, 0, 1, 1, 1,
                    8'h05, 1'b1, 8'h05, {8'hAB, 8'h11, 8'h00, 1'b0}, 8'h03, {8'h30, 8'h31, 8'h07, 1'b1}};
        vecs[1] = '{"same_key_tail", 1'b1, 8'h03, 8'h70, 8'h22, 1'b1, 8'h09, 2'd1, 3'd3, 2, 1, 0, 0,
                    8'h00, 1'b0, 8'h07, {8'h70, 8'h22, 8'h00, 1'b0}, 8'h09, 25'd0};
        vecs[2] = '{"same_key_head", 1'b1, 8'h03, 8'h30, 8'h44, 1'b1, 8'h09, 2'd1, 3'd1, 1, 1, 0, 0,
                    8'h00, 1'b0, 8'h03, {8'h30, 8'h44, 8'h07, 1'b1}, 8'h07, {8'h70, 8'h71, 8'h00, 1'b0}};
        vecs[3] = '{"append_tail", 1'b1, 8'h03, 8'h55, 8'h66, 1'b1, 8'h09, 2'd0, 3'd4, 2, 2, 1, 0,
                    8'h00, 1'b0, 8'h09, {8'h55, 8'h66, 8'h00, 1'b0}, 8'h07, {8'h70, 8'h71, 8'h09, 1'b1}};
        vecs[4] = '{"full_on_tail", 1'b1, 8'h03, 8'h55, 8'h66, 1'b0, 8'h09, 2'd2, 3'd4, 2, 0, 0, 0,
                    8'h00, 1'b0, 8'h09, 25'd0, 8'h07, {8'h70, 8'h71, 8'h00, 1'b0}};
        vecs[5] = '{"full_no_head", 1'b0, 8'h00, 8'hAB, 8'h11, 1'b0, 8'h05, 2'd2, 3'd0, 0, 0, 0, 0,
                    8'h00, 1'b0, 8'h05, 25'd0, 8'h03, {8'h30, 8'h31, 8'h07, 1'b1}};
        vecs[6] = '{"append_single", 1'b1, 8'h07, 8'h99, 8'hAA, 1'b1, 8'h0A, 2'd0, 3'd4, 1, 2, 1, 0,
                    8'h00, 1'b0, 8'h0A, {8'h99, 8'hAA, 8'h00, 1'b0}, 8'h07, {8'h70, 8'h71, 8'h0A, 1'b1}};
        vecs[7] = '{"head_is_tail", 1'b1, 8'h07, 8'h70, 8'h5A, 1'b1, 8'h0A, 2'd1, 3'd1, 1, 1, 0, 0,
                    8'h00, 1'b0, 8'h07, {8'h70, 8'h5A, 8'h00, 1'b0}, 8'h03, {8'h30, 8'h31, 8'h07, 1'b1}};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready",   {31'd0, task_ready_o},       32'd1);
        chk("rst_valid",   {31'd0, result_valid_o},     32'd0);
        chk("rst_strobes", {28'd0, rd_en_o, wr_en_o, empty_ptr_rd_ack_o, u_head_if.wr_en}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Result held stable under back-pressure while a new task waits
        clear_model();
        task_i          = {8'hAB, 8'h11, 8'h00, 1'b0};
        empty_ptr_i     = 8'h05;
        empty_ptr_val_i = 1'b1;
        result_ready_i  = 1'b0;
        task_valid_i    = 1'b1;
        @(negedge clk);
        task_i = {8'hCD, 8'hEF, 8'h03, 1'b1};
        for (int c = 0; c < 20 && !result_valid_o; c++) @(negedge clk);
        chk("bp_result_seen", {31'd0, result_valid_o}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_result", {11'd0, result_o}, {11'd0, 8'hAB, 8'h11, 2'd0, 3'd0});
            chk("bp_valid",  {31'd0, result_valid_o}, 32'd1);
            chk("bp_ready",  {31'd0, task_ready_o},   32'd0);
        end
        task_valid_i   = 1'b0;
        result_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_release_idle", {31'd0, task_ready_o}, 32'd1);
        chk("bp_single_ack",   n_ack, 1);
        chk("bp_rd_none",      n_rd,  0);

        // Reset in the middle of a chain walk
        clear_model();
        task_i          = {8'h55, 8'h66, 8'h03, 1'b1};
        empty_ptr_i     = 8'h09;
        empty_ptr_val_i = 1'b1;
        task_valid_i    = 1'b1;
        @(negedge clk);
        task_valid_i    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ready",   {31'd0, task_ready_o}, 32'd1);
        chk("midrst_strobes", {28'd0, rd_en_o, wr_en_o, empty_ptr_rd_ack_o, u_head_if.wr_en}, 32'd0);
        chk("midrst_valid",   {31'd0, result_valid_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_no_write", n_wr,  0);
        chk("midrst_no_ack",   n_ack, 0);
        chk("midrst_ram7",     {7'd0, ram[7]}, {7'd0, 8'h70, 8'h71, 8'h00, 1'b0});
        chk("ack_without_free", n_bad_ack, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
